// File: rtl/reg_read_stage_pkg.sv
// Shared types and sizes for the register-read stage: physical register index,
// operand word, and the entry format held in the output slot and skid buffer.
package reg_read_stage_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned UOP_W     = 16;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [UOP_W-1:0]  uop_t;

    typedef struct packed {
        xlen_t src1;
        xlen_t src2;
        preg_t dst;
        uop_t  uop;
    } rr_entry_t;

endpackage

// File: rtl/reg_read_stage_operand_bypass_mux.sv
// Per-source operand select: hardwired zero for preg 0, then same-cycle writeback
// bypass, then the register file's pre-write read data.
module reg_read_stage_operand_bypass_mux
    import reg_read_stage_pkg::*;
(
    input  preg_t src_preg,
    input  xlen_t rf_val,
    input  logic  wb_valid,
    input  preg_t wb_dst_reg,
    input  xlen_t wb_val,
    output xlen_t operand
);

    always_comb begin
        operand = rf_val;
        // preg 0 test comes first so a writeback to preg 0 is never forwarded
        if (src_preg == '0) begin
            operand = '0;
        end else if (wb_valid && (wb_dst_reg == src_preg)) begin
            operand = wb_val;
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage for one FU pipe: reads sources, merges writeback bypass and
// feeds execute through an output slot backed by a one-entry skid register.
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  logic [PREG_W-1:0]  iss_src1_preg,
    input  logic [PREG_W-1:0]  iss_src2_preg,
    input  logic [PREG_W-1:0]  iss_dst_preg,
    input  logic [UOP_W-1:0]   iss_uop,
    output logic [PREG_W-1:0]  rf_src1_reg,
    output logic [PREG_W-1:0]  rf_src2_reg,
    input  logic [XLEN-1:0]    rf_src1_val,
    input  logic [XLEN-1:0]    rf_src2_val,
    input  logic               wb_valid,
    input  logic [PREG_W-1:0]  wb_dst_reg,
    input  logic [XLEN-1:0]    wb_val,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_src1_val,
    output logic [XLEN-1:0]    ex_src2_val,
    output logic [PREG_W-1:0]  ex_dst_reg,
    output logic [UOP_W-1:0]   ex_uop
);

    rr_entry_t out_q, out_d;
    rr_entry_t skid_q, skid_d;
    logic      out_valid_q, out_valid_d;
    logic      skid_valid_q, skid_valid_d;
    xlen_t     op1, op2;
    rr_entry_t new_entry;
    logic      accept;

    assign rf_src1_reg = iss_src1_preg;
    assign rf_src2_reg = iss_src2_preg;

    reg_read_stage_operand_bypass_mux u_mux_src1 (
        .src_preg   (iss_src1_preg),
        .rf_val     (rf_src1_val),
        .wb_valid   (wb_valid),
        .wb_dst_reg (wb_dst_reg),
        .wb_val     (wb_val),
        .operand    (op1)
    );

    reg_read_stage_operand_bypass_mux u_mux_src2 (
        .src_preg   (iss_src2_preg),
        .rf_val     (rf_src2_val),
        .wb_valid   (wb_valid),
        .wb_dst_reg (wb_dst_reg),
        .wb_val     (wb_val),
        .operand    (op2)
    );

    // Ready comes straight from a flop so issue never sees a combinational path from execute
    assign iss_ready = ~skid_valid_q;
    assign accept    = iss_valid & iss_ready;

    always_comb begin
        new_entry.src1 = op1;
        new_entry.src2 = op2;
        new_entry.dst  = iss_dst_preg;
        new_entry.uop  = iss_uop;
    end

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case ({out_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept) begin
                        out_d       = new_entry;
                        out_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (ex_ready) begin
                        if (accept) begin
                            out_d = new_entry;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end else if (accept) begin
                        skid_d       = new_entry;
                        skid_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (ex_ready) begin
                        out_d        = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign ex_valid    = out_valid_q;
    assign ex_src1_val = out_q.src1;
    assign ex_src2_val = out_q.src2;
    assign ex_dst_reg  = out_q.dst;
    assign ex_uop      = out_q.uop;

endmodule
